// File: rtl/grf_scoreboard.sv
// rtl/grf_scoreboard.sv - register file with two read ports, two write ports and per-register pending bits
// Pending bits track issued-but-not-written-back producers so the hazard unit can stall decode.
module grf_scoreboard #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   output logic              RDY1,
   output logic              RDY2,
   input  logic              WE0,
   input  logic [ADDR_W-1:0] WA0,
   input  logic [DATA_W-1:0] WD0,
   input  logic              WE1,
   input  logic [ADDR_W-1:0] WA1,
   input  logic [DATA_W-1:0] WD1,
   input  logic              ISSUE,
   input  logic [ADDR_W-1:0] ISSUE_A,
   input  logic              FLUSH,
   output logic [ADDR_W:0]   PEND_CNT
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam bit ZR    = (ZERO_REG != 0);
   localparam bit BP    = (BYPASS != 0);

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DEPTH-1:0]  pend_q, pend_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              wen0, wen1;
   logic [ADDR_W-1:0] ra   [2];
   logic [DATA_W-1:0] rd   [2];
   logic              rdy  [2];

   assign wen0 = WE0 && !(ZR && (WA0 == '0));
   assign wen1 = WE1 && !(ZR && (WA1 == '0));

   assign ra[0]    = A1;
   assign ra[1]    = A2;
   assign RD1      = rd[0];
   assign RD2      = rd[1];
   assign RDY1     = rdy[0];
   assign RDY2     = rdy[1];
   assign PEND_CNT = cnt_q;

   // Port 1 (mult/div) outranks port 0 both for forwarding and for storage.
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd[p]  = regs_q[ra[p]];
         rdy[p] = !pend_q[ra[p]];
         if (ZR && (ra[p] == '0)) begin
            rd[p]  = '0;
            rdy[p] = 1'b1;
         end else if (BP && wen1 && (WA1 == ra[p])) begin
            rd[p]  = WD1;
            rdy[p] = 1'b1;
         end else if (BP && wen0 && (WA0 == ra[p])) begin
            rd[p]  = WD0;
            rdy[p] = 1'b1;
         end
      end
   end

   // A fresh issue supersedes a same-cycle writeback to the same register.
   always_comb begin
      pend_d = pend_q;
      cnt_d  = '0;
      for (int r = 0; r < DEPTH; r++) begin
         if (FLUSH)
            pend_d[r] = 1'b0;
         else if (ISSUE && (ISSUE_A == ADDR_W'(r)) && !(ZR && (r == 0)))
            pend_d[r] = 1'b1;
         else if ((wen0 && (WA0 == ADDR_W'(r))) || (wen1 && (WA1 == ADDR_W'(r))))
            pend_d[r] = 1'b0;
         cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[r]};
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int r = 0; r < DEPTH; r++) regs_q[r] <= '0;
      end else begin
         if (wen0) regs_q[WA0] <= WD0;
         if (wen1) regs_q[WA1] <= WD1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb/tb_grf_scoreboard.sv - scoreboard bench for grf_scoreboard (default, no-bypass and 64x8 instances)
module tb_grf_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [4:0]  a1, a2, wa0, wa1, isa;
   logic [31:0] wd0, wd1;
   logic        we0, we1, iss, fl;
   logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1;
   logic        rdy1_0, rdy2_0, rdy1_1, rdy2_1;
   logic [5:0]  cnt_0, cnt_1;

   logic [2:0]  b_a1, b_a2, b_wa0, b_wa1, b_isa;
   logic [63:0] b_wd0, b_wd1, b_rd1, b_rd2;
   logic        b_we0, b_we1, b_iss, b_fl, b_rdy1, b_rdy2;
   logic [3:0]  b_cnt;

   grf_scoreboard u0 (
      .CLK(clk), .RESET(rst_n), .A1(a1), .A2(a2), .RD1(rd1_0), .RD2(rd2_0),
      .RDY1(rdy1_0), .RDY2(rdy2_0), .WE0(we0), .WA0(wa0), .WD0(wd0),
      .WE1(we1), .WA1(wa1), .WD1(wd1), .ISSUE(iss), .ISSUE_A(isa),
      .FLUSH(fl), .PEND_CNT(cnt_0));

   grf_scoreboard #(.BYPASS(0)) u1 (
      .CLK(clk), .RESET(rst_n), .A1(a1), .A2(a2), .RD1(rd1_1), .RD2(rd2_1),
      .RDY1(rdy1_1), .RDY2(rdy2_1), .WE0(we0), .WA0(wa0), .WD0(wd0),
      .WE1(we1), .WA1(wa1), .WD1(wd1), .ISSUE(iss), .ISSUE_A(isa),
      .FLUSH(fl), .PEND_CNT(cnt_1));

   grf_scoreboard #(.DATA_W(64), .ADDR_W(3)) u2 (
      .CLK(clk), .RESET(rst_n), .A1(b_a1), .A2(b_a2), .RD1(b_rd1), .RD2(b_rd2),
      .RDY1(b_rdy1), .RDY2(b_rdy2), .WE0(b_we0), .WA0(b_wa0), .WD0(b_wd0),
      .WE1(b_we1), .WA1(b_wa1), .WD1(b_wd1), .ISSUE(b_iss), .ISSUE_A(b_isa),
      .FLUSH(b_fl), .PEND_CNT(b_cnt));

   localparam int S_RD1 = 0, S_RDY1 = 1, S_RD2 = 2, S_RDY2 = 3, S_CNT = 4;
   localparam int N_RD1 = 5, N_RDY1 = 6, N_CNT = 7;
   localparam int B_RD1 = 8, B_RDY1 = 9, B_RD2 = 10, B_CNT = 11;

   typedef struct {
      string       name;
      int          sel;
      logic [63:0] val;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [63:0] obs(input int s);
      case (s)
         S_RD1:   return {32'h0, rd1_0};
         S_RDY1:  return {63'h0, rdy1_0};
         S_RD2:   return {32'h0, rd2_0};
         S_RDY2:  return {63'h0, rdy2_0};
         S_CNT:   return {58'h0, cnt_0};
         N_RD1:   return {32'h0, rd1_1};
         N_RDY1:  return {63'h0, rdy1_1};
         N_CNT:   return {58'h0, cnt_1};
         B_RD1:   return b_rd1;
         B_RDY1:  return {63'h0, b_rdy1};
         B_RD2:   return b_rd2;
         B_CNT:   return {60'h0, b_cnt};
         default: return 64'hx;
      endcase
   endfunction

   // Expectations are consumed on the falling edge, mid-cycle between input changes.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t        e;
         logic [63:0] act;
         e   = q.pop_front();
         act = obs(e.sel);
         checks++;
         if (act !== e.val) begin
            failures++;
            $display("FAIL %s: got %h expected %h", e.name, act, e.val);
         end
      end
   end

   task automatic ex(input string n, input int s, input logic [63:0] v);
      exp_t e;
      e.name = n;
      e.sel  = s;
      e.val  = v;
      q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      we0 = 0; we1 = 0; iss = 0; fl = 0;
      b_we0 = 0; b_we1 = 0; b_iss = 0; b_fl = 0;
   endtask

   initial begin
      rst_n = 0;
      a1 = 0; a2 = 0; wa0 = 0; wa1 = 0; isa = 0; wd0 = 0; wd1 = 0;
      b_a1 = 0; b_a2 = 0; b_wa0 = 0; b_wa1 = 0; b_isa = 0; b_wd0 = 0; b_wd1 = 0;
      idle();
      step();
      ex("reset_rd1", S_RD1, 0); ex("reset_cnt", S_CNT, 0); ex("reset_rdy1", S_RDY1, 1);
      ex("reset_b_cnt", B_CNT, 0);
      step();
      rst_n = 1;

      // load state, then assert reset mid-cycle
      we0 = 1; wa0 = 10; wd0 = 32'h55; we1 = 1; wa1 = 11; wd1 = 32'h66; iss = 1; isa = 12;
      step(); idle(); a1 = 10; a2 = 11;
      ex("load_rd1", S_RD1, 32'h55); ex("load_rd2", S_RD2, 32'h66); ex("load_cnt", S_CNT, 1);
      step();
      rst_n = 0;
      ex("async_rd1", S_RD1, 0); ex("async_rd2", S_RD2, 0); ex("async_cnt", S_CNT, 0);
      step();
      rst_n = 1;

      // zero register
      we0 = 1; wa0 = 0; wd0 = 32'hDEAD_BEEF; iss = 1; isa = 0; a1 = 0;
      ex("zero_rd1_comb", S_RD1, 0); ex("zero_rdy1_comb", S_RDY1, 1);
      step(); idle();
      ex("zero_rd1_post", S_RD1, 0); ex("zero_rdy1_post", S_RDY1, 1); ex("zero_cnt", S_CNT, 0);
      step();

      // bypass vs. no bypass
      we0 = 1; wa0 = 5; wd0 = 32'h1234_5678; a1 = 5;
      ex("byp_rd1", S_RD1, 32'h1234_5678); ex("byp_rdy1", S_RDY1, 1); ex("nobyp_rd1_pre", N_RD1, 0);
      step(); idle();
      ex("byp_rd1_post", S_RD1, 32'h1234_5678); ex("nobyp_rd1_post", N_RD1, 32'h1234_5678);
      step();

      // dual-write conflict and distinct addresses
      we0 = 1; wa0 = 7; wd0 = 32'h1; we1 = 1; wa1 = 7; wd1 = 32'h2; a1 = 7;
      ex("conf_byp_prio", S_RD1, 32'h2);
      step(); idle();
      ex("conf_rd7", S_RD1, 32'h2); ex("conf_rd7_nobyp", N_RD1, 32'h2);
      step();
      we0 = 1; wa0 = 7; wd0 = 32'h1; we1 = 1; wa1 = 8; wd1 = 32'h2;
      step(); idle(); a1 = 7; a2 = 8;
      ex("dist_rd7", S_RD1, 32'h1); ex("dist_rd8", S_RD2, 32'h2);
      step();

      // scoreboard set and clear by writeback
      iss = 1; isa = 3; a1 = 3;
      step(); idle();
      ex("sb_rdy3", S_RDY1, 0); ex("sb_cnt1", S_CNT, 1); ex("sb_rdy3_nobyp", N_RDY1, 0);
      step();
      we1 = 1; wa1 = 3; wd1 = 32'h99;
      ex("sb_wb_rdy", S_RDY1, 1); ex("sb_wb_rd", S_RD1, 32'h99);
      ex("sb_wb_rdy_nobyp", N_RDY1, 0); ex("sb_wb_rd_nobyp", N_RD1, 0);
      step(); idle();
      ex("sb_cnt0", S_CNT, 0); ex("sb_rdy_post", S_RDY1, 1); ex("sb_cnt0_nobyp", N_CNT, 0);
      step();

      // issue/write collision
      iss = 1; isa = 4; a1 = 4;
      step(); idle();
      ex("col_pre_cnt", S_CNT, 1);
      iss = 1; isa = 4; we0 = 1; wa0 = 4; wd0 = 32'hAA;
      ex("col_byp_rdy", S_RDY1, 1);
      step(); idle();
      ex("col_rd4", S_RD1, 32'hAA); ex("col_rdy4", S_RDY1, 0); ex("col_cnt", S_CNT, 1);
      step();

      // fill, zero-reg issue, flush
      for (int i = 1; i < 32; i++) begin
         iss = 1; isa = 5'(i);
         step();
      end
      idle();
      ex("fill_cnt31", S_CNT, 31);
      iss = 1; isa = 0;
      step(); idle();
      ex("issue0_cnt31", S_CNT, 31);
      fl = 1; iss = 1; isa = 9; a1 = 9;
      step(); idle();
      ex("flush_cnt", S_CNT, 0); ex("flush_rdy9", S_RDY1, 1);
      step();

      // 64-bit, 8-deep instance
      b_we0 = 1; b_wa0 = 6; b_wd0 = 64'hDEAD_BEEF_0123_4567; b_a1 = 6;
      ex("b_byp_rd1", B_RD1, 64'hDEAD_BEEF_0123_4567);
      step(); idle();
      b_iss = 1; b_isa = 6; b_we1 = 1; b_wa1 = 7; b_wd1 = 64'hFFFF_0000_FFFF_0001;
      step(); idle(); b_a2 = 7;
      ex("b_rd1", B_RD1, 64'hDEAD_BEEF_0123_4567); ex("b_rdy1", B_RDY1, 0);
      ex("b_rd2", B_RD2, 64'hFFFF_0000_FFFF_0001); ex("b_cnt1", B_CNT, 1);
      for (int i = 0; i < 8; i++) begin
         b_iss = 1; b_isa = 3'(i);
         step();
      end
      idle();
      ex("b_fill_cnt7", B_CNT, 7);
      b_we0 = 1; b_wa0 = 0; b_wd0 = 64'h1; b_a1 = 0;
      ex("b_zero_rd1", B_RD1, 0); ex("b_zero_rdy1", B_RDY1, 1);
      step(); idle();
      b_fl = 1;
      step(); idle();
      ex("b_flush_cnt", B_CNT, 0); ex("b_zero_rd1_post", B_RD1, 0);
      step();
      step();

      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending expectations expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
